// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out frame transmitter.
package piso_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

  function automatic int unsigned frame_len(input int unsigned data_w,
                                            input int unsigned parity_en,
                                            input int unsigned stop_bits);
    return 1 + data_w + parity_en + stop_bits;
  endfunction

endpackage

// File: rtl/piso_shift_core.sv
// Loadable payload shift register; presents the next line bit at ser_out.
module piso_shift_core #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 0
) (
  input  logic             SRclk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] load_data,
  output logic             ser_out
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load) begin
      sr_d = load_data;
    end else if (shift) begin
      if (MSB_FIRST != 0) begin
        sr_d = {sr_q[WIDTH-2:0], 1'b0};
      end else begin
        sr_d = {1'b0, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_ff @(posedge SRclk or posedge reset) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign ser_out = (MSB_FIRST != 0) ? sr_q[WIDTH-1] : sr_q[0];

endmodule

// File: rtl/piso_frame_tx.sv
// Framed serial transmitter: one-entry holding buffer, frame FSM and parity around a shift core.
module piso_frame_tx #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned PARITY_EN  = 0,
  parameter int unsigned PARITY_ODD = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned MSB_FIRST  = 0
) (
  input  logic              SRclk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              data_out,
  output logic              busy,
  output logic              tx_done
);
  import piso_pkg::*;

  localparam int unsigned FrameLen = frame_len(DATA_W, PARITY_EN, STOP_BITS);
  localparam int unsigned CntW     = $clog2(DATA_W + 1);
  localparam int unsigned PosW     = $clog2(FrameLen);

  tx_state_e        state_q, state_d;
  logic [DATA_W-1:0] buf_q, buf_d;
  logic             buf_full_q, buf_full_d;
  logic             par_q, par_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [PosW-1:0]  pos_q, pos_d;
  logic             data_out_q, data_out_d;
  logic             tx_done_q, tx_done_d;
  logic             load, shift, ser, start_frame;

  piso_shift_core #(
    .WIDTH    (DATA_W),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .SRclk    (SRclk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .load_data(buf_q),
    .ser_out  (ser)
  );

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    buf_full_d  = buf_full_q;
    par_d       = par_q;
    bit_cnt_d   = bit_cnt_q;
    pos_d       = pos_q;
    data_out_d  = data_out_q;
    tx_done_d   = 1'b0;
    load        = 1'b0;
    shift       = 1'b0;
    start_frame = 1'b0;

    if (in_valid && !buf_full_q) begin
      buf_d      = data_in;
      buf_full_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        data_out_d  = 1'b1;
        start_frame = buf_full_q;
      end
      StStart: begin
        state_d    = StData;
        data_out_d = ser;
        shift      = 1'b1;
        bit_cnt_d  = '0;
        pos_d      = pos_q + 1'b1;
      end
      StData: begin
        pos_d = pos_q + 1'b1;
        if (bit_cnt_q == CntW'(DATA_W - 1)) begin
          if (PARITY_EN != 0) begin
            state_d    = StParity;
            data_out_d = par_q;
          end else begin
            state_d    = StStop;
            data_out_d = 1'b1;
          end
        end else begin
          bit_cnt_d  = bit_cnt_q + 1'b1;
          data_out_d = ser;
          shift      = 1'b1;
        end
      end
      StParity: begin
        state_d    = StStop;
        data_out_d = 1'b1;
        pos_d      = pos_q + 1'b1;
      end
      StStop: begin
        data_out_d = 1'b1;
        if (pos_q == PosW'(FrameLen - 1)) begin
          tx_done_d   = 1'b1;
          state_d     = StIdle;
          start_frame = buf_full_q;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end
      default: begin
        state_d    = StIdle;
        data_out_d = 1'b1;
      end
    endcase

    // Buffer full at idle or final stop: chain straight into the next start bit.
    if (start_frame) begin
      load       = 1'b1;
      buf_full_d = 1'b0;
      par_d      = (^buf_q) ^ (PARITY_ODD != 0);
      state_d    = StStart;
      data_out_d = 1'b0;
      bit_cnt_d  = '0;
      pos_d      = '0;
    end
  end

  always_ff @(posedge SRclk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      par_q      <= 1'b0;
      bit_cnt_q  <= '0;
      pos_q      <= '0;
      data_out_q <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      par_q      <= par_d;
      bit_cnt_q  <= bit_cnt_d;
      pos_q      <= pos_d;
      data_out_q <= data_out_d;
      tx_done_q  <= tx_done_d;
    end
  end

  assign in_ready = ~buf_full_q;
  assign busy     = (state_q != StIdle);
  assign data_out = data_out_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_piso_frame_tx.sv
// Directed bench: four configurations share stimulus; frames compared against hand-built tables.
module tb_piso_frame_tx;

  logic       SRclk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       in_valid;
  wire  [3:0] dout, bsy, rdy, done;

  int total = 0;
  int bad   = 0;

  always #5 SRclk = ~SRclk;

  // 0: defaults, 1: even parity, 2: odd parity, 3: MSB first with two stop bits
  piso_frame_tx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1), .MSB_FIRST(0)) u_a (
    .SRclk(SRclk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy[0]), .data_out(dout[0]), .busy(bsy[0]), .tx_done(done[0]));
  piso_frame_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1), .MSB_FIRST(0)) u_b (
    .SRclk(SRclk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy[1]), .data_out(dout[1]), .busy(bsy[1]), .tx_done(done[1]));
  piso_frame_tx #(.DATA_W(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1), .MSB_FIRST(0)) u_c (
    .SRclk(SRclk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy[2]), .data_out(dout[2]), .busy(bsy[2]), .tx_done(done[2]));
  piso_frame_tx #(.DATA_W(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2), .MSB_FIRST(1)) u_d (
    .SRclk(SRclk), .reset(reset), .data_in(data_in), .in_valid(in_valid),
    .in_ready(rdy[3]), .data_out(dout[3]), .busy(bsy[3]), .tx_done(done[3]));

  // Frames written left to right in line order.
  typedef struct {
    logic [7:0]  word;
    logic [9:0]  fa;
    logic [10:0] fb;
    logic [10:0] fc;
    logic [10:0] fd;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((bsy != 4'h0 || rdy != 4'hF) && n < 60) begin
      @(negedge SRclk);
      n++;
    end
    check("idle_wait", {24'b0, bsy, rdy}, 32'h0000_000F);
  endtask

  task automatic run_vec(input int i);
    logic [11:0] cap[4];
    logic [11:0] capt[4];
    logic [11:0] exp_l[4];
    wait_idle();
    @(negedge SRclk);
    data_in  = tbl[i].word;
    in_valid = 1'b1;
    @(negedge SRclk);
    in_valid = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge SRclk);
      for (int d = 0; d < 4; d++) begin
        cap[d][11-k]  = dout[d];
        capt[d][11-k] = done[d];
      end
    end
    exp_l[0] = {tbl[i].fa, 2'b11};
    exp_l[1] = {tbl[i].fb, 1'b1};
    exp_l[2] = {tbl[i].fc, 1'b1};
    exp_l[3] = {tbl[i].fd, 1'b1};
    for (int d = 0; d < 4; d++) begin
      check($sformatf("line_cfg%0d_w%02h", d, tbl[i].word), {20'b0, cap[d]}, {20'b0, exp_l[d]});
      check($sformatf("done_cfg%0d_w%02h", d, tbl[i].word), {20'b0, capt[d]},
            (d == 0) ? 32'h002 : 32'h001);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    logic [21:0] b_line, b_done, b_rdy, e_done, e_rdy;
    logic        any_done, all_high, any_busy;

    tbl[0] = '{8'hA5, 10'b0_10100101_1, 11'b0_10100101_0_1, 11'b0_10100101_1_1,
               11'b0_10100101_11};
    tbl[1] = '{8'h01, 10'b0_10000000_1, 11'b0_10000000_1_1, 11'b0_10000000_0_1,
               11'b0_00000001_11};
    tbl[2] = '{8'h80, 10'b0_00000001_1, 11'b0_00000001_1_1, 11'b0_00000001_0_1,
               11'b0_10000000_11};
    tbl[3] = '{8'h3C, 10'b0_00111100_1, 11'b0_00111100_0_1, 11'b0_00111100_1_1,
               11'b0_00111100_11};
    tbl[4] = '{8'h6B, 10'b0_11010110_1, 11'b0_11010110_1_1, 11'b0_11010110_0_1,
               11'b0_01101011_11};

    reset    = 1'b1;
    in_valid = 1'b0;
    data_in  = 8'h00;
    repeat (3) @(negedge SRclk);
    check("rst_line", {28'b0, dout}, 32'hF);
    check("rst_busy", {28'b0, bsy}, 32'h0);
    check("rst_ready", {28'b0, rdy}, 32'hF);
    check("rst_done", {28'b0, done}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) run_vec(i);

    // Back-to-back words with in_valid held and data changing while not ready.
    wait_idle();
    @(negedge SRclk);
    data_in  = 8'h3C;
    in_valid = 1'b1;
    @(negedge SRclk);
    check("b2b_ready_after_accept", {31'b0, rdy[0]}, 32'h0);
    data_in = 8'h55;
    for (int k = 0; k < 22; k++) begin
      @(negedge SRclk);
      b_line[21-k] = dout[0];
      b_done[21-k] = done[0];
      b_rdy[21-k]  = rdy[0];
      if (k == 0) data_in = 8'hC3;
      if (k == 1) data_in = 8'h0F;
      if (k == 3) in_valid = 1'b0;
    end
    e_done = '0;
    e_done[21-10] = 1'b1;
    e_done[21-20] = 1'b1;
    for (int k = 0; k < 22; k++) e_rdy[21-k] = (k == 0 || k >= 10);
    check("b2b_line", {10'b0, b_line}, {10'b0, 10'b0_00111100_1, 10'b0_11000011_1, 2'b11});
    check("b2b_done", {10'b0, b_done}, {10'b0, e_done});
    check("b2b_ready", {10'b0, b_rdy}, {10'b0, e_rdy});

    // Reset mid-frame with a second word buffered.
    wait_idle();
    @(negedge SRclk);
    data_in  = 8'h6B;
    in_valid = 1'b1;
    @(negedge SRclk);
    data_in = 8'h5A;
    @(negedge SRclk);
    @(negedge SRclk);
    in_valid = 1'b0;
    repeat (4) @(negedge SRclk);
    check("mid_bit4", {31'b0, dout[0]}, 32'h0);
    check("mid_busy", {31'b0, bsy[0]}, 32'h1);
    check("mid_buffered", {31'b0, rdy[0]}, 32'h0);
    #2 reset = 1'b1;
    #1;
    check("async_line", {28'b0, dout}, 32'hF);
    check("async_busy", {28'b0, bsy}, 32'h0);
    check("async_ready", {28'b0, rdy}, 32'hF);
    check("async_done", {28'b0, done}, 32'h0);
    @(negedge SRclk);
    reset    = 1'b0;
    any_done = 1'b0;
    all_high = 1'b1;
    any_busy = 1'b0;
    repeat (14) begin
      @(negedge SRclk);
      any_done = any_done | (|done);
      all_high = all_high & (&dout);
      any_busy = any_busy | (|bsy);
    end
    check("post_rst_no_done", {31'b0, any_done}, 32'h0);
    check("post_rst_line_high", {31'b0, all_high}, 32'h1);
    check("post_rst_idle", {31'b0, any_busy}, 32'h0);

    run_vec(0);
    run_vec(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
